serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Sequencer that time-shares one full-adder cell and one 2:1 operand mux to add or subtract two WIDTH-bit operands bit-serially, LSB first.
- Operands are latched on a start request and shifted through the adder one bit per clock.
- The carry is held in a flop between bits.
- The result and a done pulse are presented after WIDTH cycles.
- Sits between a register-file/control unit and the shared bit-level arithmetic cells.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
clk  input  1  single system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
sub  input  1  0 = a+b+cin; 1 = a-b (mux selects ~b, carry-in forced 1, cin ignored)
a  input  WIDTH  operand A, sampled with accepted start
b  input  WIDTH  operand B, sampled with accepted start
cin  input  1  carry-in for add mode, sampled with accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  result, held until next accepted start
cout  output  1  final carry out (sub mode: 1 = no borrow)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, bit counter and carry flop cleared.
  - Takes effect immediately, without waiting for a clock edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 -> RUN.
  - At E0: latch opA=a; opB = sub ? ~b : b; carry = sub ? 1 : cin; count=0; busy=1.
  - start=0 -> stay in IDLE.
- RUN: each edge E1..E_WIDTH:
  - s = opA[0]^opB[0]^carry; carry <= majority(opA[0],opB[0],carry).
  - opA and opB shift right by 1; s shifts into the MSB of the result register; count increments.
  - At E_WIDTH (count reaches WIDTH-1 before the edge) -> DONE.
  - At that edge: sum <= final result, cout <= final carry, busy=0, done=1.
- DONE: lasts exactly one cycle.
  - start=1 -> accepted exactly as in IDLE, go to RUN; done falls and busy rises at the same edge.
  - Otherwise -> IDLE, done=0.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH clocks after the accepting edge.
- Throughput: back-to-back ops every WIDTH+1 clocks.
- start asserted while in RUN: ignored, not queued, no effect on the operation in progress.
- a, b, cin and sub may change freely after the accepting edge.
- Visible sum/cout change only at the DONE-entry edge; no partial results are visible.
- Arithmetic: result is modulo 2^WIDTH; cout is the true carry out of the MSB.
- Counter width: clog2(WIDTH) bits.

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined:
  - Adds output port ovf (1 bit): signed overflow = carry into MSB XOR carry out of MSB.
  - Captured at the DONE-entry edge and held alongside sum.
  - Reset value 0.
  - Needs one extra flop recording the carry into the last bit.
- Not defined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, sub=0, a=0x5A, b=0x33, cin=0, start pulse -> busy=1 for 8 cycles; done pulse 8 clocks after the accepting edge; sum=0x8D, cout=0.
- sub=0, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Repeat with cin=1, a=0xFE, b=0x00 -> sum=0xFF, cout=0.
- sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1. Then sub=1, a=0x00, b=0x01 issued during the DONE cycle -> accepted with no IDLE gap; sum=0xFF, cout=0.
- Start op 0x12+0x34; pulse start with a=0xFF, b=0xFF at cycle 3 of RUN -> ignored; result sum=0x46, cout=0; only one done pulse.
- rst_n low for half a cycle at cycle 4 of RUN -> busy, done, sum, cout go to 0 immediately; no done pulse follows; next start a=0x01, b=0x02 -> sum=0x03.
- With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01, sub=0 -> sum=0x80, ovf=1; a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1; a=0x05, b=0x03, sub=0 -> ovf=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder/subtractor sequencer.
// One full-adder cell and one operand mux are time-shared over WIDTH clocks,
// LSB first. The carry is held in a flop between bits, and the result is
// published in a single step when the last bit has been added.
// Optional build macro SERIAL_ADD_OVF_EN adds a signed-overflow output (ovf).
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-2:0] res;    // result bits collected so far, newest at the MSB
    logic [CW-1:0]    count;
    logic             carry;

    // Shared full-adder cell working on the current LSBs of the operands.
    logic             bit_sum;
    logic             bit_carry;
    logic [WIDTH-1:0] res_next;

    assign bit_sum   = op_a[0] ^ op_b[0] ^ carry;
    assign bit_carry = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    // On the final bit this is the complete result: new bit on top of the
    // WIDTH-1 bits already collected.
    assign res_next  = {bit_sum, res};

    // Sequencer: operand capture, one adder step per RUN clock, registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset as well, so an aborted
            // operation leaves no stale operands or carry behind.
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            count <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples the pre-edge values of the others.
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: the mux picks ~b and the
                        // carry flop is preset, ignoring cin.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        res   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= bit_carry;
                    res   <= res_next[WIDTH-1:1];
                    count <= count + 1'b1;
                    if (count == LAST_BIT) begin
                        // carry still holds the carry into the MSB here.
                        sum   <= res_next;
                        cout  <= bit_carry;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= carry ^ bit_carry;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: directed vectors, scoreboard queue of
// expected results, separate monitor popping on every done pulse.
// Define SERIAL_ADD_OVF_EN for both files to exercise the ovf output.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                check("sb_has_entry", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
                    check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                end
            end
        end
    end

    // Issue one operation at the current negedge; returns at the following
    // negedge, with inputs scrambled to show they are not needed after capture.
    task automatic launch(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vcin, input logic vsub,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        exp_t e;
        e.sum = es; e.cout = ec; e.ovf = eo;
        a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        check("busy_after_accept", 32'(busy), 1);
        check("done_low_after_accept", 32'(done), 0);
    endtask

    // Wait (bounded) for done; optionally pulse start with junk operands at
    // negedge number pulse_at inside RUN.
    task automatic await_done(input int pulse_at);
        int lat  = 0;
        bit seen = 1'b0;
        while (lat < WIDTH + 4 && !seen) begin
            @(negedge clk);
            lat++;
            if (lat == pulse_at) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF;
            end else if (lat == pulse_at + 1) begin
                start = 1'b0;
            end
            if (done === 1'b1) seen = 1'b1;
            else if (lat == WIDTH - 1) check("busy_last_run_cycle", 32'(busy), 1);
        end
        check("done_seen", 32'(seen), 1);
        check("latency", 32'(lat), 32'(WIDTH));
        check("busy_low_at_done", 32'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sum", 32'(sum), 0);
        check("reset_cout", 32'(cout), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain add.
        launch(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
        await_done(-1);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);

        // Wrap to zero with carry out, then carry-in only.
        launch(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        await_done(-1);
        @(negedge clk);
        launch(8'hFE, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        await_done(-1);
        @(negedge clk);

        // Subtract (cin=1 must be ignored), then back-to-back from DONE.
        launch(8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);
        await_done(-1);
        launch(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        await_done(-1);
        @(negedge clk);

        // start during RUN is ignored.
        launch(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
        await_done(3);
        repeat (WIDTH + 3) @(negedge clk);
        check("no_op_from_ignored_start", 32'(busy), 0);

        // Asynchronous reset in the middle of an operation.
        launch(8'h55, 8'h0F, 1'b0, 1'b0, 8'h64, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_sum", 32'(sum), 0);
        check("midrst_cout", 32'(cout), 0);
`ifdef SERIAL_ADD_OVF_EN
        check("midrst_ovf", 32'(ovf), 0);
`endif
        #3 rst_n = 1'b1;
        repeat (WIDTH + 3) @(negedge clk);
        check("idle_after_midrst", 32'(busy), 0);

        launch(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);
        await_done(-1);
        @(negedge clk);

        // Signed overflow corner cases (ovf checked when the feature is built).
        launch(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        await_done(-1);
        @(negedge clk);
        launch(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        await_done(-1);
        @(negedge clk);
        launch(8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);
        await_done(-1);

        repeat (WIDTH + 3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
